// File: rtl/cnn_pkg.sv
// Shared CNN constants and helpers.
//  - conv2 result / activation widths and conv2 feature-map geometry
//  - per-channel conv2 bias constants
//  - relu_sat(): clamp negative values to 0 and positive values to the largest
//    positive value representable in a signed out_w-bit word
package cnn_pkg;

  localparam int CONV2_OUT_W    = 14;
  localparam int ACT_W          = 12;
  localparam int CONV2_FMAP_W   = 8;
  localparam int CONV2_FMAP_H   = 8;
  localparam int CONV2_CHANNELS = 4;

  localparam logic signed [CONV2_OUT_W-1:0] CONV2_BIAS [CONV2_CHANNELS] = '{
    14'sd0, 14'sd50, -14'sd20, 14'sd7
  };

  function automatic logic signed [31:0] relu_sat(input logic signed [31:0] value,
                                                  input int                 out_w);
    logic signed [31:0] top_val;
    top_val = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    if (value < 0)
      return 32'sd0;
    else if (value > top_val)
      return top_val;
    else
      return value;
  endfunction

endpackage

// File: rtl/pool2_linebuf.sv
// One-row line buffer for 2x2 pooling: holds the horizontal max of each
// window's top row until the bottom row of the same window arrives.
// Ports:
//   clk      clock, rising edge
//   wr_en    write strobe
//   wr_addr  slot to write (window column index)
//   wr_data  value written
//   rd_addr  slot to read (combinational read)
//   rd_data  contents of slot rd_addr
// Contents are not reset: every slot is rewritten on an even row before the
// following odd row reads it.
module pool2_linebuf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 12,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  slot_we;

  // One-hot write decode per slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = wr_en && (wr_addr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) mem[i] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/conv2_relu_pool.sv
// conv2 post-processing: bias add, ReLU with saturation to the activation
// width, then 2x2 / stride-2 max pooling over a raster-ordered stream.
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   conv_in         signed conv2 result of the current pixel
//   valid_in        conv_in valid this cycle (gaps allowed, no backpressure)
//   pool_out        signed pooled activation (holds when not valid)
//   valid_out_pool  one-cycle pulse per pooled pixel
//   frame_done      pulse coincident with the last pooled pixel of a frame
// Pipeline: S1 registers the activated pixel with its col/row tags; S2 forms
// the horizontal pair max, parks it in the line buffer on even rows and
// combines it with the parked value on odd rows.
module conv2_relu_pool
  import cnn_pkg::*;
#(
  parameter int                     IN_W   = CONV2_OUT_W,
  parameter int                     OUT_W  = ACT_W,
  parameter int                     FMAP_W = CONV2_FMAP_W,
  parameter int                     FMAP_H = CONV2_FMAP_H,
  parameter logic signed [IN_W-1:0] BIAS   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  conv_in,
  input  logic                    valid_in,
  output logic signed [OUT_W-1:0] pool_out,
  output logic                    valid_out_pool,
  output logic                    frame_done
);

  localparam int CW = $clog2(FMAP_W);
  localparam int RW = $clog2(FMAP_H);
  localparam int AW = (FMAP_W > 2) ? $clog2(FMAP_W / 2) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(FMAP_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(FMAP_H - 1);

  // Raster position of the pixel currently on conv_in.
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (valid_in) begin
      if (col_reg == LAST_COL) begin
        col_reg <= '0;
        row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // S1: bias add one bit wider than the input so the sum cannot wrap.
  logic signed [IN_W:0]      sum;
  logic signed [OUT_W-1:0]   r1_next;
  logic signed [OUT_W-1:0]   r1_reg;
  logic [CW-1:0]             col1_reg;
  logic [RW-1:0]             row1_reg;
  logic                      v1_reg;

  assign sum     = {conv_in[IN_W-1], conv_in} + {BIAS[IN_W-1], BIAS};
  assign r1_next = OUT_W'(relu_sat(32'(sum), OUT_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      r1_reg   <= '0;
      col1_reg <= '0;
      row1_reg <= '0;
    end else begin
      v1_reg <= valid_in;
      if (valid_in) begin
        r1_reg   <= r1_next;
        col1_reg <= col_reg;
        row1_reg <= row_reg;
      end
    end
  end

  // S2: pair max and vertical combine through the line buffer.
  logic signed [OUT_W-1:0] h_reg;
  logic signed [OUT_W-1:0] pm;
  logic signed [OUT_W-1:0] pool_next;
  logic [OUT_W-1:0]        lb_rd_data;
  logic [AW-1:0]           lb_addr;
  logic                    lb_wr_en;

  assign pm        = (r1_reg > h_reg) ? r1_reg : h_reg;
  assign pool_next = ($signed(lb_rd_data) > pm) ? $signed(lb_rd_data) : pm;
  assign lb_addr   = AW'(col1_reg >> 1);
  assign lb_wr_en  = v1_reg && col1_reg[0] && !row1_reg[0];

  pool2_linebuf #(
    .DEPTH  (FMAP_W / 2),
    .DATA_W (OUT_W),
    .AW     (AW)
  ) u_linebuf (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (pm),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg          <= '0;
      pool_out       <= '0;
      valid_out_pool <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      valid_out_pool <= 1'b0;
      frame_done     <= 1'b0;
      if (v1_reg) begin
        if (!col1_reg[0]) begin
          h_reg <= r1_reg;
        end else if (row1_reg[0]) begin
          pool_out       <= pool_next;
          valid_out_pool <= 1'b1;
          frame_done     <= (row1_reg == LAST_ROW) && (col1_reg == LAST_COL);
        end
      end
    end
  end

endmodule
